round_controller: RTL and testbench
===================================

Name: round_controller

Overview:
- Game-round sequencer for the sprite collision datapath.
- Each 60 Hz frame it issues load strobes (ld_x, then ld_y) to the collision comparator, then samples the comparator's hit result one cycle later.
- Per round it runs a frame-tick time limit, and across rounds it tracks score and lives.
- Sits between the player input/HUD logic and the collision detector, and replaces that detector's internal timeout as the authority on round outcome.

Parameters:
- ROUND_TICKS, 180, base round length in frame ticks (1..255)
- MIN_TICKS, 60, floor on round length (1..ROUND_TICKS)
- TICK_STEP, 10, round-length reduction per point scored
- HOLD_TICKS, 60, frames the WIN/LOSE result is held before the next round (1..255)
- LIVES, 3, lives granted at game start (1..7)
- SCORE_W, 8, score counter width

Ports:
- clk, input, 1, system clock
- reset, input, 1, asynchronous active-high reset
- sixty, input, 1, frame tick, one-cycle pulse at 60 Hz, synchronous to clk
- start, input, 1, player start, one-cycle pulse
- hit, input, 1, collision result from the detector, valid in the cycle check=1
- ld_x, output, 1, one-cycle strobe: detector latches X coordinates
- ld_y, output, 1, one-cycle strobe: detector latches Y coordinates
- check, output, 1, one-cycle strobe: controller samples hit this cycle
- round_active, output, 1, high from round start until outcome
- win_pulse, output, 1, one cycle on collision detected
- lose_pulse, output, 1, one cycle on round timeout
- score, output, SCORE_W, rounds won, saturating
- lives, output, 3, lives remaining
- time_left, output, 8, frame ticks remaining in current round
- game_over, output, 1, high in GAME_OVER

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, port reset.
- Reset values: state=IDLE, every strobe and pulse 0, round_active=0, game_over=0, score=0, lives=LIVES, time_left=0. Reset asserted mid-round aborts the round immediately; no pulse is emitted.
- States: IDLE, ARM, WAIT_TICK, LOAD_X, LOAD_Y, CHECK, WIN, LOSE, GAME_OVER.
- IDLE:
  - On start, score is cleared, lives=LIVES, and the state goes to ARM.
  - sixty is ignored.
- ARM (one cycle):
  - Computes limit = ROUND_TICKS - score*TICK_STEP in 16-bit unsigned arithmetic.
  - If the subtraction underflows or the result is below MIN_TICKS, limit = MIN_TICKS.
  - Loads time_left=limit, sets round_active=1, goes to WAIT_TICK.
- WAIT_TICK:
  - On sixty: time_left decrements and the state goes to LOAD_X. If time_left was 1, a timeout-pending flag is set.
- LOAD_X: ld_x=1 for one cycle, then LOAD_Y.
- LOAD_Y: ld_y=1 for one cycle, then CHECK.
- CHECK: check=1 for one cycle. Outcome is resolved in this cycle:
  - hit=1: go to WIN. win_pulse=1 on entry; score increments, holding at all-ones.
  - Else, timeout-pending: go to LOSE. lose_pulse=1 on entry; lives decrements.
  - Else: return to WAIT_TICK.
  - hit and timeout in the same frame: hit wins.
- Frame latency: ld_x is 1 cycle after sixty, ld_y 2 cycles, check 3 cycles, win/lose pulse 4 cycles.
- sixty pulses arriving in LOAD_X, LOAD_Y or CHECK are dropped, because the frame period far exceeds 3 cycles.
- WIN/LOSE:
  - round_active=0; time_left holds its value.
  - A hold counter counts sixty pulses; after HOLD_TICKS pulses:
    - lives==0 goes to GAME_OVER;
    - otherwise goes to ARM, so the next round uses the updated score.
  - start in WIN/LOSE is ignored.
- GAME_OVER: game_over=1, score and lives hold. On start, score is cleared, lives=LIVES, and the state goes to ARM.
- start in any running state (ARM..CHECK) is ignored.
- lives never decrements below 0.
- time_left never wraps: the timeout flag is set when the value reaches 0.

Decomposition:
- Shared package game_pkg:
  - state enum round_state_t;
  - defaults FRAME_HZ=60, SPRITE_SIZE=31, COORD_W=9 (shared with the collision detector and sprite drawers).
- One sub-module, frame_tick_counter:
  - 8-bit down/up counter with inputs clear, load value, enable (the sixty pulse);
  - output terminal flag.
  - Two instances: the round timer (time_left) and the hold timer.
- Remaining FSM and score/lives registers stay in round_controller.

Test Plan:
1. Reset, start pulse, hold hit=0, apply 180 sixty pulses → lose_pulse exactly once, 4 cycles after the 180th sixty. lives 3→2, time_left=0, score=0. After 60 more sixty pulses, round_active=1 and time_left=180.
2. Start; on the 5th frame drive hit=1 in the check cycle → win_pulse once, score=1, time_left=175. Next round starts with time_left=170 after the 60-tick hold.
3. Force score to 12, enter ARM → limit 180-120=60, so time_left=60. Score 13 or 20 → time_left=60 (clamp, including underflow case).
4. hit=1 on the frame where time_left reaches 0 → win_pulse=1, lose_pulse=0, lives unchanged.
5. Three consecutive timeouts from LIVES=3 → lives=0, game_over=1 after the third hold. A start pulse then gives score=0, lives=3, round_active=1.
6. Assert reset mid-LOAD_Y → all outputs at reset values, no win/lose pulse; a sixty pulse during LOAD_X produces no second ld_x.

Source files
------------

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game types, sprite defaults and round length helper
package game_pkg;

  localparam int FRAME_HZ    = 60;
  localparam int SPRITE_SIZE = 31;
  localparam int COORD_W     = 9;

  typedef enum logic [3:0] {
    IDLE,
    ARM,
    WAIT_TICK,
    LOAD_X,
    LOAD_Y,
    CHECK,
    WIN,
    LOSE,
    GAME_OVER
  } round_state_t;

  // Rounds shorten as the score rises; an underflowing or too-short result clamps to the floor.
  function automatic logic [7:0] round_limit(
    input logic [15:0] score,
    input logic [15:0] base_ticks,
    input logic [15:0] floor_ticks,
    input logic [15:0] step_ticks
  );
    logic [15:0] cut;
    logic [15:0] lim;
    cut = score * step_ticks;
    lim = base_ticks - cut;
    if (cut > base_ticks || lim < floor_ticks) begin
      lim = floor_ticks;
    end
    return lim[7:0];
  endfunction

endpackage

// File: rtl/frame_tick_counter.sv
// rtl/frame_tick_counter.sv - 8-bit saturating frame tick counter with load and clear
module frame_tick_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       load,
  input  logic [7:0] load_value,
  input  logic       enable,
  input  logic       up,
  output logic [7:0] count,
  output logic       terminal
);

  // Clear beats load beats count; the count never wraps in either direction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (load) begin
      count <= load_value;
    end else if (enable) begin
      if (up) begin
        if (count != 8'hff) begin
          count <= count + 8'd1;
        end
      end else if (count != 8'd0) begin
        count <= count - 8'd1;
      end
    end
  end

  assign terminal = up ? (count == 8'hff) : (count == 8'd0);

endmodule

// File: rtl/round_controller.sv
// rtl/round_controller.sv - game round sequencer driving the sprite collision detector
module round_controller #(
  parameter int ROUND_TICKS = 180,
  parameter int MIN_TICKS   = 60,
  parameter int TICK_STEP   = 10,
  parameter int HOLD_TICKS  = 60,
  parameter int LIVES       = 3,
  parameter int SCORE_W     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sixty,
  input  logic               start,
  input  logic               hit,
  output logic               ld_x,
  output logic               ld_y,
  output logic               check,
  output logic               round_active,
  output logic               win_pulse,
  output logic               lose_pulse,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         lives,
  output logic [7:0]         time_left,
  output logic               game_over
);

  import game_pkg::*;

  round_state_t state, state_n;

  logic       game_start;
  logic       round_load;
  logic       round_en;
  logic       round_zero;
  logic       hold_load;
  logic       hold_en;
  logic       hold_zero;
  logic       hold_done;
  logic [7:0] limit;
  logic [7:0] hold_count_unused;

  assign game_start = start && (state == IDLE || state == GAME_OVER);
  assign limit      = round_limit(16'(score), 16'(ROUND_TICKS), 16'(MIN_TICKS), 16'(TICK_STEP));
  assign round_load = (state == ARM);
  assign round_en   = sixty && (state == WAIT_TICK);
  // Hold timer is primed on every check so it is ready whichever way the round resolves.
  assign hold_load  = (state == CHECK);
  assign hold_en    = sixty && (state == WIN || state == LOSE);
  assign hold_done  = hold_en && hold_zero;

  frame_tick_counter u_round_timer (
    .clk        (clk),
    .reset      (reset),
    .clear      (game_start),
    .load       (round_load),
    .load_value (limit),
    .enable     (round_en),
    .up         (1'b0),
    .count      (time_left),
    .terminal   (round_zero)
  );

  frame_tick_counter u_hold_timer (
    .clk        (clk),
    .reset      (reset),
    .clear      (1'b0),
    .load       (hold_load),
    .load_value (8'(HOLD_TICKS - 1)),
    .enable     (hold_en),
    .up         (1'b0),
    .count      (hold_count_unused),
    .terminal   (hold_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n      = state;
    ld_x         = 1'b0;
    ld_y         = 1'b0;
    check        = 1'b0;
    round_active = 1'b0;
    game_over    = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_n = ARM;
      end
      ARM: begin
        state_n = WAIT_TICK;
      end
      WAIT_TICK: begin
        round_active = 1'b1;
        if (sixty) state_n = LOAD_X;
      end
      LOAD_X: begin
        round_active = 1'b1;
        ld_x         = 1'b1;
        state_n      = LOAD_Y;
      end
      LOAD_Y: begin
        round_active = 1'b1;
        ld_y         = 1'b1;
        state_n      = CHECK;
      end
      CHECK: begin
        round_active = 1'b1;
        check        = 1'b1;
        // A hit on the final frame still counts as a win.
        if (hit)             state_n = WIN;
        else if (round_zero) state_n = LOSE;
        else                 state_n = WAIT_TICK;
      end
      WIN, LOSE: begin
        if (hold_done) state_n = (lives == 3'd0) ? GAME_OVER : ARM;
      end
      GAME_OVER: begin
        game_over = 1'b1;
        if (start) state_n = ARM;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score      <= '0;
      lives      <= 3'(LIVES);
      win_pulse  <= 1'b0;
      lose_pulse <= 1'b0;
    end else begin
      win_pulse  <= (state == CHECK) && hit;
      lose_pulse <= (state == CHECK) && !hit && round_zero;
      if (game_start) begin
        score <= '0;
        lives <= 3'(LIVES);
      end else if (state == CHECK) begin
        if (hit) begin
          if (score != '1) score <= score + SCORE_W'(1);
        end else if (round_zero && lives != 3'd0) begin
          lives <= lives - 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_round_controller.sv
// tb/tb_round_controller.sv - randomized scoreboard bench for round_controller
module tb_round_controller;

  localparam int ROUND_TICKS = 180;
  localparam int MIN_TICKS   = 60;
  localparam int TICK_STEP   = 10;
  localparam int HOLD_TICKS  = 60;
  localparam int LIVES       = 3;
  localparam int SCORE_W     = 8;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               sixty = 1'b0;
  logic               start = 1'b0;
  logic               hit = 1'b0;
  logic               ld_x, ld_y, check, round_active, win_pulse, lose_pulse, game_over;
  logic [SCORE_W-1:0] score;
  logic [2:0]         lives;
  logic [7:0]         time_left;

  round_controller #(
    .ROUND_TICKS (ROUND_TICKS),
    .MIN_TICKS   (MIN_TICKS),
    .TICK_STEP   (TICK_STEP),
    .HOLD_TICKS  (HOLD_TICKS),
    .LIVES       (LIVES),
    .SCORE_W     (SCORE_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sixty        (sixty),
    .start        (start),
    .hit          (hit),
    .ld_x         (ld_x),
    .ld_y         (ld_y),
    .check        (check),
    .round_active (round_active),
    .win_pulse    (win_pulse),
    .lose_pulse   (lose_pulse),
    .score        (score),
    .lives        (lives),
    .time_left    (time_left),
    .game_over    (game_over)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    int          v0;
    int          v1;
    int          v2;
    bit          win;
  } exp_t;

  exp_t q_ldx[$];
  exp_t q_ldy[$];
  exp_t q_chk[$];
  exp_t q_out[$];
  exp_t q_start[$];
  exp_t q_go[$];

  int n_total = 0;
  int n_pass  = 0;
  int m_score, m_lives, m_time;

  task automatic chk(input string name, input longint got, input longint want);
    n_total++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
  endtask

  task automatic unexpected(input string name);
    n_total++;
    $display("FAIL %s: DUT asserted it at cycle %0d, expected none", name, cyc);
  endtask

  function automatic int exp_limit(input int s);
    int v;
    v = ROUND_TICKS - s * TICK_STEP;
    return (v < MIN_TICKS) ? MIN_TICKS : v;
  endfunction

  logic prev_ra = 1'b0;
  logic prev_go = 1'b0;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset) begin
      prev_ra <= 1'b0;
      prev_go <= 1'b0;
    end else begin
      if (ld_x) begin
        if (q_ldx.size() == 0) unexpected("ld_x");
        else begin e = q_ldx.pop_front(); chk("ld_x_cycle", cyc, e.cyc); end
      end
      if (ld_y) begin
        if (q_ldy.size() == 0) unexpected("ld_y");
        else begin e = q_ldy.pop_front(); chk("ld_y_cycle", cyc, e.cyc); end
      end
      if (check) begin
        if (q_chk.size() == 0) unexpected("check");
        else begin
          e = q_chk.pop_front();
          chk("check_cycle", cyc, e.cyc);
          chk("time_left_at_check", time_left, e.v0);
          chk("round_active_at_check", round_active, 1);
        end
      end
      if (win_pulse || lose_pulse) begin
        if (q_out.size() == 0) unexpected("win_or_lose_pulse");
        else begin
          e = q_out.pop_front();
          chk("outcome_cycle", cyc, e.cyc);
          chk("win_pulse", win_pulse, e.win);
          chk("lose_pulse", lose_pulse, !e.win);
          chk("score_after_outcome", score, e.v0);
          chk("lives_after_outcome", lives, e.v1);
          chk("time_left_after_outcome", time_left, e.v2);
          chk("round_active_after_outcome", round_active, 0);
        end
      end
      if (round_active && !prev_ra) begin
        if (q_start.size() == 0) unexpected("round_start");
        else begin
          e = q_start.pop_front();
          chk("round_start_cycle", cyc, e.cyc);
          chk("round_start_time_left", time_left, e.v0);
          chk("round_start_score", score, e.v1);
          chk("round_start_lives", lives, e.v2);
        end
      end
      if (game_over && !prev_go) begin
        if (q_go.size() == 0) unexpected("game_over");
        else begin
          e = q_go.pop_front();
          chk("game_over_cycle", cyc, e.cyc);
          chk("game_over_score", score, e.v0);
          chk("game_over_lives", lives, e.v1);
        end
      end
      prev_ra <= round_active;
      prev_go <= game_over;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_gap(input bit allow_start);
    int n;
    int sp;
    n  = int'($urandom_range(5, 9));
    sp = (allow_start && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, n - 2)) : -1;
    for (int i = 0; i < n; i++) begin
      start = (i == sp);
      tick();
    end
    start = 1'b0;
  endtask

  task automatic pulse_sixty(output int unsigned c);
    sixty = 1'b1;
    c = cyc;
    tick();
    sixty = 1'b0;
  endtask

  task automatic run_frame(input bit hit_now, output bit done);
    int unsigned c;
    idle_gap(1'b1);
    hit = 1'($urandom);
    pulse_sixty(c);
    m_time--;
    q_ldx.push_back('{c + 1, 0, 0, 0, 1'b0});
    q_ldy.push_back('{c + 2, 0, 0, 0, 1'b0});
    q_chk.push_back('{c + 3, m_time, 0, 0, 1'b0});
    if ($urandom_range(0, 4) == 0) begin
      sixty = 1'b1;
      tick();
      sixty = 1'b0;
    end else begin
      tick();
    end
    tick();
    hit = hit_now;
    tick();
    hit = 1'($urandom);
    done = 1'b0;
    if (hit_now) begin
      if (m_score < 255) m_score++;
      q_out.push_back('{c + 4, m_score, m_lives, m_time, 1'b1});
      done = 1'b1;
    end else if (m_time == 0) begin
      if (m_lives > 0) m_lives--;
      q_out.push_back('{c + 4, m_score, m_lives, m_time, 1'b0});
      done = 1'b1;
    end
  endtask

  task automatic hold_phase();
    int unsigned h;
    h = 0;
    for (int k = 0; k < HOLD_TICKS; k++) begin
      idle_gap(1'b0);
      pulse_sixty(h);
    end
    if (m_lives == 0) begin
      q_go.push_back('{h + 1, m_score, 0, 0, 1'b0});
    end else begin
      m_time = exp_limit(m_score);
      q_start.push_back('{h + 2, m_time, m_score, m_lives, 1'b0});
    end
  endtask

  task automatic play_round(input int hit_frame);
    bit done;
    int f;
    f = 0;
    done = 1'b0;
    while (!done) begin
      f++;
      run_frame(f == hit_frame, done);
    end
    hold_phase();
  endtask

  task automatic do_start();
    int unsigned s;
    idle_gap(1'b0);
    start = 1'b1;
    s = cyc;
    tick();
    start = 1'b0;
    m_score = 0;
    m_lives = LIVES;
    m_time  = exp_limit(0);
    q_start.push_back('{s + 2, m_time, 0, LIVES, 1'b0});
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_score"}, score, 0);
    chk({tag, "_lives"}, lives, LIVES);
    chk({tag, "_time_left"}, time_left, 0);
    chk({tag, "_round_active"}, round_active, 0);
    chk({tag, "_game_over"}, game_over, 0);
    chk({tag, "_win_pulse"}, win_pulse, 0);
    chk({tag, "_lose_pulse"}, lose_pulse, 0);
    chk({tag, "_ld_x"}, ld_x, 0);
    chk({tag, "_ld_y"}, ld_y, 0);
    chk({tag, "_check"}, check, 0);
  endtask

  initial begin : driver
    int unsigned c;
    reset = 1'b1;
    repeat (3) tick();
    check_reset_values("reset");
    reset = 1'b0;
    tick();

    repeat (3) begin
      idle_gap(1'b0);
      sixty = 1'b1;
      tick();
      sixty = 1'b0;
    end

    do_start();
    play_round(0);
    play_round(5);
    while (m_score < 20) play_round(int'($urandom_range(1, 4)));
    play_round(m_time);
    play_round(0);
    play_round(0);
    chk("game_over_after_last_life", game_over, 1);

    do_start();
    repeat (3) play_round(0);
    chk("game_over_second_game", game_over, 1);

    do_start();
    idle_gap(1'b0);
    pulse_sixty(c);
    q_ldx.push_back('{c + 1, 0, 0, 0, 1'b0});
    tick();
    chk("ld_y_before_reset", ld_y, 1);
    reset = 1'b1;
    #1;
    check_reset_values("mid_round_reset");
    tick();
    tick();
    reset = 1'b0;
    repeat (20) tick();
    check_reset_values("after_reset_release");

    chk("q_ldx_drained", q_ldx.size(), 0);
    chk("q_ldy_drained", q_ldy.size(), 0);
    chk("q_chk_drained", q_chk.size(), 0);
    chk("q_out_drained", q_out.size(), 0);
    chk("q_start_drained", q_start.size(), 0);
    chk("q_go_drained", q_go.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
